// File: rtl/wb_port_buffer.sv
// wb_port_buffer
//   Writeback staging buffer between six writeback sources and the two write ports of the
//   physical register file. Each source owns one slot, so it never loses a write when more
//   than two sources complete in the same cycle. Up to two occupied slots drain per cycle
//   with round-robin priority starting at rr_ptr, so no source starves.
//
// Ports
//   clk, rstn                      clock (rising edge), asynchronous active-low reset
//   flush                          drop every pending write; no accept, no drain this cycle
//   wr<N>_valid/_address/_data     writeback from source N (N = 1..6)
//   wr<N>_ready                    slot N can take a write this cycle
//   wr_first_*                     regfile write port 0 (highest-priority occupied slot)
//   wr_second_*                    regfile write port 1 (next occupied slot in scan order)
//   pending_cnt                    number of occupied slots, registered state

module wb_port_buffer #(
  parameter int unsigned REG_ADDR_WIDTH = 6,
  parameter int unsigned REG_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flush,
  input  logic                      wr1_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wr1_address,
  input  logic [REG_DATA_WIDTH-1:0] wr1_data,
  output logic                      wr1_ready,
  input  logic                      wr2_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wr2_address,
  input  logic [REG_DATA_WIDTH-1:0] wr2_data,
  output logic                      wr2_ready,
  input  logic                      wr3_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wr3_address,
  input  logic [REG_DATA_WIDTH-1:0] wr3_data,
  output logic                      wr3_ready,
  input  logic                      wr4_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wr4_address,
  input  logic [REG_DATA_WIDTH-1:0] wr4_data,
  output logic                      wr4_ready,
  input  logic                      wr5_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wr5_address,
  input  logic [REG_DATA_WIDTH-1:0] wr5_data,
  output logic                      wr5_ready,
  input  logic                      wr6_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wr6_address,
  input  logic [REG_DATA_WIDTH-1:0] wr6_data,
  output logic                      wr6_ready,
  output logic                      wr_first_valid,
  output logic [REG_ADDR_WIDTH-1:0] wr_first_address,
  output logic [REG_DATA_WIDTH-1:0] wr_first_data,
  output logic                      wr_second_valid,
  output logic [REG_ADDR_WIDTH-1:0] wr_second_address,
  output logic [REG_DATA_WIDTH-1:0] wr_second_data,
  output logic [2:0]                pending_cnt
);

  localparam int unsigned NumSlots = 6;

  // Adds two slot indices modulo NumSlots; both operands are already < NumSlots.
  function automatic logic [2:0] wrap_add(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 4'(NumSlots)) sum = sum - 4'(NumSlots);
    return sum[2:0];
  endfunction

  // Pack the per-source ports so the slot logic can be written once.
  logic [NumSlots-1:0]       in_valid;
  logic [REG_ADDR_WIDTH-1:0] in_addr [NumSlots];
  logic [REG_DATA_WIDTH-1:0] in_data [NumSlots];
  logic [NumSlots-1:0]       ready;

  assign in_valid = {wr6_valid, wr5_valid, wr4_valid, wr3_valid, wr2_valid, wr1_valid};
  assign in_addr[0] = wr1_address;
  assign in_addr[1] = wr2_address;
  assign in_addr[2] = wr3_address;
  assign in_addr[3] = wr4_address;
  assign in_addr[4] = wr5_address;
  assign in_addr[5] = wr6_address;
  assign in_data[0] = wr1_data;
  assign in_data[1] = wr2_data;
  assign in_data[2] = wr3_data;
  assign in_data[3] = wr4_data;
  assign in_data[4] = wr5_data;
  assign in_data[5] = wr6_data;
  assign wr1_ready = ready[0];
  assign wr2_ready = ready[1];
  assign wr3_ready = ready[2];
  assign wr4_ready = ready[3];
  assign wr5_ready = ready[4];
  assign wr6_ready = ready[5];

  // Slot state
  logic [NumSlots-1:0]       occ_q, occ_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q [NumSlots];
  logic [REG_ADDR_WIDTH-1:0] addr_d [NumSlots];
  logic [REG_DATA_WIDTH-1:0] data_q [NumSlots];
  logic [REG_DATA_WIDTH-1:0] data_d [NumSlots];
  logic [2:0]                rr_ptr_q, rr_ptr_d;

  // Grant scan: purely from registered occupancy, never from incoming valids.
  logic       first_found, second_found;
  logic [2:0] first_idx, second_idx, scan_idx;

  always_comb begin
    first_found  = 1'b0;
    second_found = 1'b0;
    first_idx    = '0;
    second_idx   = '0;
    scan_idx     = '0;
    for (int k = 0; k < NumSlots; k++) begin
      scan_idx = wrap_add(rr_ptr_q, 3'(k));
      if (occ_q[scan_idx]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = scan_idx;
        end else if (!second_found) begin
          second_found = 1'b1;
          second_idx   = scan_idx;
        end
      end
    end
  end

  // A flush suppresses both grants, so nothing drains and rr_ptr holds.
  logic first_grant, second_grant;
  logic [NumSlots-1:0] granted;

  assign first_grant  = first_found && !flush;
  assign second_grant = second_found && !flush;

  always_comb begin
    granted = '0;
    for (int i = 0; i < NumSlots; i++) begin
      granted[i] = (first_grant && (first_idx == 3'(i))) ||
                   (second_grant && (second_idx == 3'(i)));
    end
  end

  // rstn gates ready so no source sees an accept while reset is held.
  always_comb begin
    ready = '0;
    for (int i = 0; i < NumSlots; i++) begin
      ready[i] = rstn && !flush && (!occ_q[i] || granted[i]);
    end
  end

  // Next state: load wins over drain, which gives same-cycle drain-and-refill.
  always_comb begin
    occ_d = occ_q;
    for (int i = 0; i < NumSlots; i++) begin
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
      if (flush) begin
        occ_d[i] = 1'b0;
      end else if (in_valid[i] && ready[i]) begin
        occ_d[i]  = 1'b1;
        addr_d[i] = in_addr[i];
        data_d[i] = in_data[i];
      end else if (granted[i]) begin
        occ_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (second_grant) begin
      rr_ptr_d = wrap_add(second_idx, 3'd1);
    end else if (first_grant) begin
      rr_ptr_d = wrap_add(first_idx, 3'd1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ_q    <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      occ_q    <= occ_d;
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NumSlots; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  // Write ports: an invalid port drives zeros on address and data.
  assign wr_first_valid    = first_grant;
  assign wr_first_address  = first_grant ? addr_q[first_idx] : '0;
  assign wr_first_data     = first_grant ? data_q[first_idx] : '0;
  assign wr_second_valid   = second_grant;
  assign wr_second_address = second_grant ? addr_q[second_idx] : '0;
  assign wr_second_data    = second_grant ? data_q[second_idx] : '0;

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < NumSlots; i++) begin
      pending_cnt = pending_cnt + 3'(occ_q[i]);
    end
  end

endmodule

// File: tb/tb_wb_port_buffer.sv
// Self-checking bench for wb_port_buffer: a table of per-cycle vectors for the six-source
// burst and round-robin fairness, plus hand-written sequences for single write,
// back-to-back, flush and asynchronous reset.

module tb_wb_port_buffer;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic [5:0]  v;
  logic [5:0]  a [6];
  logic [63:0] d [6];
  logic        r1, r2, r3, r4, r5, r6;
  logic [5:0]  rdy;
  logic        fv, sv;
  logic [5:0]  fa, sa;
  logic [63:0] fd, sd;
  logic [2:0]  pend;

  int total;
  int bad;

  assign rdy = {r6, r5, r4, r3, r2, r1};

  wb_port_buffer #(
    .REG_ADDR_WIDTH(6),
    .REG_DATA_WIDTH(64)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .flush            (flush),
    .wr1_valid        (v[0]),
    .wr1_address      (a[0]),
    .wr1_data         (d[0]),
    .wr1_ready        (r1),
    .wr2_valid        (v[1]),
    .wr2_address      (a[1]),
    .wr2_data         (d[1]),
    .wr2_ready        (r2),
    .wr3_valid        (v[2]),
    .wr3_address      (a[2]),
    .wr3_data         (d[2]),
    .wr3_ready        (r3),
    .wr4_valid        (v[3]),
    .wr4_address      (a[3]),
    .wr4_data         (d[3]),
    .wr4_ready        (r4),
    .wr5_valid        (v[4]),
    .wr5_address      (a[4]),
    .wr5_data         (d[4]),
    .wr5_ready        (r5),
    .wr6_valid        (v[5]),
    .wr6_address      (a[5]),
    .wr6_data         (d[5]),
    .wr6_ready        (r6),
    .wr_first_valid   (fv),
    .wr_first_address (fa),
    .wr_first_data    (fd),
    .wr_second_valid  (sv),
    .wr_second_address(sa),
    .wr_second_data   (sd),
    .pending_cnt      (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus; source N drives addr = 8*N + tag, data = 16*tag + N.
  typedef struct {
    logic [5:0]  valid;
    logic [3:0]  tag;
    logic        fv;
    logic [5:0]  fa;
    logic [63:0] fd;
    logic        sv;
    logic [5:0]  sa;
    logic [63:0] sd;
    logic [5:0]  rdy;
    logic [2:0]  pend;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_ports(input string tag, input logic efv, input logic [5:0] efa,
                           input logic [63:0] efd, input logic esv, input logic [5:0] esa,
                           input logic [63:0] esd);
    chk({tag, ".first_valid"}, 64'(fv), 64'(efv));
    chk({tag, ".first_addr"}, 64'(fa), 64'(efa));
    chk({tag, ".first_data"}, fd, efd);
    chk({tag, ".second_valid"}, 64'(sv), 64'(esv));
    chk({tag, ".second_addr"}, 64'(sa), 64'(esa));
    chk({tag, ".second_data"}, sd, esd);
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    v = '0;
    for (int n = 0; n < 6; n++) begin
      a[n] = '0;
      d[n] = '0;
    end
  endtask

  task automatic drive(input int n, input logic [5:0] addr, input logic [63:0] data);
    v[n - 1] = 1'b1;
    a[n - 1] = addr;
    d[n - 1] = data;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    rstn = 1'b0;

    //                valid      tag   fv  fa     fd       sv  sa     sd       rdy        pend
    tbl[0] = '{6'b111111, 4'd1, 1'b0, 6'd0,  64'h00, 1'b0, 6'd0,  64'h00, 6'b111111, 3'd0};
    tbl[1] = '{6'b000000, 4'd1, 1'b1, 6'd9,  64'h11, 1'b1, 6'd17, 64'h12, 6'b000011, 3'd6};
    tbl[2] = '{6'b000000, 4'd1, 1'b1, 6'd25, 64'h13, 1'b1, 6'd33, 64'h14, 6'b001111, 3'd4};
    tbl[3] = '{6'b000000, 4'd1, 1'b1, 6'd41, 64'h15, 1'b1, 6'd49, 64'h16, 6'b111111, 3'd2};
    tbl[4] = '{6'b000000, 4'd1, 1'b0, 6'd0,  64'h00, 1'b0, 6'd0,  64'h00, 6'b111111, 3'd0};
    // Fairness: slot 6 pending while sources 1 and 2 keep refilling.
    tbl[5] = '{6'b100011, 4'd2, 1'b0, 6'd0,  64'h00, 1'b0, 6'd0,  64'h00, 6'b111111, 3'd0};
    tbl[6] = '{6'b000011, 4'd3, 1'b1, 6'd10, 64'h21, 1'b1, 6'd18, 64'h22, 6'b011111, 3'd3};
    tbl[7] = '{6'b000001, 4'd4, 1'b1, 6'd50, 64'h26, 1'b1, 6'd11, 64'h31, 6'b111101, 3'd3};
    tbl[8] = '{6'b000000, 4'd4, 1'b1, 6'd19, 64'h32, 1'b1, 6'd12, 64'h41, 6'b111111, 3'd2};
    tbl[9] = '{6'b000000, 4'd4, 1'b0, 6'd0,  64'h00, 1'b0, 6'd0,  64'h00, 6'b111111, 3'd0};

    // Reset state
    #12;
    chk("reset.pending", 64'(pend), 64'd0);
    chk("reset.ready", 64'(rdy), 64'd0);
    chk_ports("reset", 1'b0, '0, '0, 1'b0, '0, '0);
    rstn = 1'b1;
    next_cycle();

    for (int i = 0; i < 10; i++) begin
      flush = 1'b0;
      v = tbl[i].valid;
      for (int n = 0; n < 6; n++) begin
        a[n] = 6'((n + 1) * 8 + int'(tbl[i].tag));
        d[n] = 64'(int'(tbl[i].tag) * 16 + n + 1);
      end
      #1;
      chk_ports($sformatf("vec%0d", i), tbl[i].fv, tbl[i].fa, tbl[i].fd,
                tbl[i].sv, tbl[i].sa, tbl[i].sd);
      chk($sformatf("vec%0d.ready", i), 64'(rdy), 64'(tbl[i].rdy));
      chk($sformatf("vec%0d.pending", i), 64'(pend), 64'(tbl[i].pend));
      next_cycle();
    end

    // Single source: wr3 addr 5 data 0xAA, visible one cycle later.
    idle_inputs();
    drive(3, 6'd5, 64'hAA);
    #1;
    chk("single.ready", 64'(r3), 64'd1);
    next_cycle();
    idle_inputs();
    #1;
    chk_ports("single.c1", 1'b1, 6'd5, 64'hAA, 1'b0, '0, '0);
    chk("single.c1.pending", 64'(pend), 64'd1);
    next_cycle();
    chk("single.c2.pending", 64'(pend), 64'd0);
    chk("single.c2.first_valid", 64'(fv), 64'd0);

    // Back-to-back on wr2: data 1..4 each written on consecutive cycles.
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      if (c < 4) drive(2, 6'd7, 64'(c + 1));
      #1;
      if (c < 4) chk($sformatf("b2b.c%0d.ready", c), 64'(r2), 64'd1);
      if (c == 0) chk_ports("b2b.c0", 1'b0, '0, '0, 1'b0, '0, '0);
      else chk_ports($sformatf("b2b.c%0d", c), 1'b1, 6'd7, 64'(c), 1'b0, '0, '0);
      next_cycle();
    end
    chk("b2b.end.pending", 64'(pend), 64'd0);

    // Flush with slots 1, 4, 5 occupied and wr2 offering a write.
    idle_inputs();
    drive(1, 6'd1, 64'h101);
    drive(4, 6'd4, 64'h104);
    drive(5, 6'd5, 64'h105);
    next_cycle();
    idle_inputs();
    flush = 1'b1;
    drive(2, 6'd2, 64'h102);
    #1;
    chk("flush.pending", 64'(pend), 64'd3);
    chk("flush.ready", 64'(rdy), 64'd0);
    chk_ports("flush", 1'b0, '0, '0, 1'b0, '0, '0);
    next_cycle();
    // rr_ptr held at 2 across the flush, so slot 3 outranks slot 1 below.
    idle_inputs();
    drive(1, 6'd21, 64'h201);
    drive(3, 6'd23, 64'h203);
    #1;
    chk("postflush.pending", 64'(pend), 64'd0);
    chk("postflush.first_valid", 64'(fv), 64'd0);
    next_cycle();
    idle_inputs();
    #1;
    chk_ports("postflush.rr", 1'b1, 6'd23, 64'h203, 1'b1, 6'd21, 64'h201);
    next_cycle();
    chk("postflush.drained", 64'(pend), 64'd0);

    // Asynchronous reset between edges with four slots full.
    idle_inputs();
    for (int n = 1; n <= 4; n++) drive(n, 6'(30 + n), 64'(32'h300 + n));
    next_cycle();
    idle_inputs();
    chk("areset.before.pending", 64'(pend), 64'd4);
    #1;
    rstn = 1'b0;
    #1;
    chk("areset.pending", 64'(pend), 64'd0);
    chk("areset.ready", 64'(rdy), 64'd0);
    chk_ports("areset", 1'b0, '0, '0, 1'b0, '0, '0);
    #2;
    rstn = 1'b1;
    next_cycle();
    // rr_ptr back at 0: slot 1 must come out ahead of slot 6.
    drive(1, 6'd9, 64'h51);
    drive(6, 6'd14, 64'h56);
    #1;
    chk("areset.rel.ready", 64'(rdy), 64'h3f);
    chk("areset.rel.first_valid", 64'(fv), 64'd0);
    next_cycle();
    idle_inputs();
    #1;
    chk_ports("areset.rel.c1", 1'b1, 6'd9, 64'h51, 1'b1, 6'd14, 64'h56);
    chk("areset.rel.pending", 64'(pend), 64'd2);
    next_cycle();
    chk("areset.rel.drained", 64'(pend), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
